// File: rtl/sram_like_slave.sv
// Responder end of the SRAM-like req/addr_ok/data_ok bus: word memory plus an
// in-order response queue with programmable minimum latency.
module sram_like_slave #(
  parameter int AW      = 12,
  parameter int MAX_OUT = 2,
  parameter int LAT     = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int TW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [31:0]   mem_q [0:(1<<AW)-1];
  logic          ent_wr_q   [MAX_OUT];
  logic [31:0]   ent_data_q [MAX_OUT];
  logic [TW-1:0] ent_cnt_q  [MAX_OUT];

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] idx;
  logic          push;
  logic          pop;

  // size is advisory and the low/high address bits are don't-care.
  logic unused_ok;
  assign unused_ok = &{1'b0, size, addr[31:AW+2], addr[1:0]};

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  assign idx     = addr[AW+1:2];
  assign addr_ok = resetn & ~stall & (count_q < CW'(MAX_OUT));
  assign push    = req & addr_ok;
  assign data_ok = (count_q != '0) && (ent_cnt_q[rd_ptr_q] == '0);
  assign pop     = data_ok;
  assign rdata   = (data_ok && !ent_wr_q[rd_ptr_q]) ? ent_data_q[rd_ptr_q] : '0;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      count_d  = count_d + CW'(1);
      wr_ptr_d = ptr_next(wr_ptr_q);
    end
    if (pop) begin
      count_d  = count_d - CW'(1);
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
  end

  // Memory and queued payload are never reset; only control state is.
  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (push) begin
      ent_wr_q[wr_ptr_q]   <= wr;
      ent_data_q[wr_ptr_q] <= wr ? 32'h0 : mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < MAX_OUT; i++) ent_cnt_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < MAX_OUT; i++) begin
        if (push && (PW'(i) == wr_ptr_q)) ent_cnt_q[i] <= TW'(LAT - 1);
        else if (ent_cnt_q[i] != '0)      ent_cnt_q[i] <= ent_cnt_q[i] - TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: three configurations driven independently and
// checked every cycle against a timestamp-based completion model.
module tb_sram_like_slave;
  logic        clk;
  logic        resetn;
  logic        req   [3];
  logic        wr    [3];
  logic        stall [3];
  logic [1:0]  size  [3];
  logic [3:0]  wstrb [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        aok   [3];
  logic        dok   [3];
  logic [31:0] rd    [3];

  localparam int MO [3] = '{2, 2, 4};
  localparam int LT [3] = '{1, 3, 2};

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  sram_like_slave #(.AW(12), .MAX_OUT(2), .LAT(1)) u0 (
    .clk(clk), .resetn(resetn), .req(req[0]), .wr(wr[0]), .size(size[0]),
    .wstrb(wstrb[0]), .addr(addr[0]), .wdata(wdata[0]), .stall(stall[0]),
    .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd[0]));
  sram_like_slave #(.AW(12), .MAX_OUT(2), .LAT(3)) u1 (
    .clk(clk), .resetn(resetn), .req(req[1]), .wr(wr[1]), .size(size[1]),
    .wstrb(wstrb[1]), .addr(addr[1]), .wdata(wdata[1]), .stall(stall[1]),
    .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd[1]));
  sram_like_slave #(.AW(12), .MAX_OUT(4), .LAT(2)) u2 (
    .clk(clk), .resetn(resetn), .req(req[2]), .wr(wr[2]), .size(size[2]),
    .wstrb(wstrb[2]), .addr(addr[2]), .wdata(wdata[2]), .stall(stall[2]),
    .addr_ok(aok[2]), .data_ok(dok[2]), .rdata(rd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] addr_of(input int idx);
    return 32'h1c00_0000 + 32'(idx) * 32'd4;
  endfunction

  function automatic logic [31:0] init_val(input int k, input int idx);
    return 32'h5A00_0000 + 32'(k) * 32'h0010_0000 + 32'(idx) * 32'h0000_0101;
  endfunction

  // Reference model: each accepted request gets a completion time of
  // max(accept + LAT, previous completion + 1); data is fixed at acceptance.
  typedef struct {
    int          due;
    logic [31:0] data;
  } ent_t;
  ent_t        mq      [3][$];
  int          lastdue [3];
  logic [31:0] mmem    [3][4096];

  initial begin
    for (int k = 0; k < 3; k++) lastdue[k] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) begin
        logic        e_aok;
        logic        e_dok;
        logic [31:0] e_rd;
        int          idx;
        int          due;
        e_aok = resetn && !stall[k] && (mq[k].size() < MO[k]);
        e_dok = (mq[k].size() > 0) && (mq[k][0].due == cyc);
        e_rd  = e_dok ? mq[k][0].data : 32'h0;
        chk($sformatf("model_addr_ok[%0d]", k), 32'(aok[k]), 32'(e_aok));
        chk($sformatf("model_data_ok[%0d]", k), 32'(dok[k]), 32'(e_dok));
        chk($sformatf("model_rdata[%0d]", k), rd[k], e_rd);
        if (!resetn) begin
          mq[k].delete();
        end else begin
          if (e_dok) void'(mq[k].pop_front());
          if (req[k] && e_aok) begin
            idx = int'(addr[k][13:2]);
            due = (cyc + LT[k] > lastdue[k] + 1) ? cyc + LT[k] : lastdue[k] + 1;
            lastdue[k] = due;
            if (wr[k]) begin
              for (int b = 0; b < 4; b++)
                if (wstrb[k][b]) mmem[k][idx][8*b +: 8] = wdata[k][8*b +: 8];
              mq[k].push_back('{due: due, data: 32'h0});
            end else begin
              mq[k].push_back('{due: due, data: mmem[k][idx]});
            end
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic put(input int k, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    req[k] = 1'b1; wr[k] = w; wstrb[k] = s; addr[k] = a; wdata[k] = d; size[k] = 2'b10;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (aok[k]) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL put_timeout[%0d]: addr_ok stayed 0, required 1", k);
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic rd_check(input int k, input int idx, input logic [31:0] ev, input string nm);
    bit got = 1'b0;
    put(k, 1'b0, 4'h0, addr_of(idx), 32'h0);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (dok[k]) begin got = 1'b1; chk(nm, rd[k], ev); end
      @(posedge clk); #1;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL %s: data_ok never seen, required one pulse", nm);
    end
  endtask

  typedef struct {
    logic        req, wr, stall;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic        eaok, edok;
    logic [31:0] erd;
  } vec_t;

  task automatic table_test();
    vec_t tbl [8];
    tbl[0] = '{1'b1, 1'b1, 1'b0, 4'hf, 32'h1c000000, 32'h12345678, 1'b1, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h1c000000, 32'h0,        1'b1, 1'b1, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 4'hf, 32'h1c000010, 32'h0,        1'b1, 1'b1, 32'h12345678};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 4'h5, 32'h1c000010, 32'hAABBCCDD, 1'b1, 1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h1c000010, 32'h0,        1'b1, 1'b1, 32'h0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h00BB00DD};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h1c000000, 32'h0,        1'b0, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      req[0] = tbl[i].req; wr[0] = tbl[i].wr; stall[0] = tbl[i].stall;
      wstrb[0] = tbl[i].wstrb; addr[0] = tbl[i].addr; wdata[0] = tbl[i].wdata;
      @(negedge clk);
      chk($sformatf("tbl%0d_addr_ok", i), 32'(aok[0]), 32'(tbl[i].eaok));
      chk($sformatf("tbl%0d_data_ok", i), 32'(dok[0]), 32'(tbl[i].edok));
      chk($sformatf("tbl%0d_rdata", i), rd[0], tbl[i].erd);
      @(posedge clk); #1;
    end
    req[0] = 1'b0; stall[0] = 1'b0;
  endtask

  task automatic full_test();
    logic [5:0] ea = 6'b110011;
    logic [5:0] ed = 6'b011000;
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = addr_of(7);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("full_addr_ok_T%0d", i), 32'(aok[1]), 32'(ea[i]));
      chk($sformatf("full_data_ok_T%0d", i), 32'(dok[1]), 32'(ed[i]));
      @(posedge clk); #1;
      if (i == 3) req[1] = 1'b0;
    end
  endtask

  task automatic stall_test();
    stall[2] = 1'b1; req[2] = 1'b1; wr[2] = 1'b0; addr[2] = addr_of(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_addr_ok_%0d", i), 32'(aok[2]), 32'h0);
      chk($sformatf("stall_data_ok_%0d", i), 32'(dok[2]), 32'h0);
      @(posedge clk); #1;
    end
    stall[2] = 1'b0;
    @(negedge clk);
    chk("stall_release_addr_ok", 32'(aok[2]), 32'h1);
    @(posedge clk); #1;
    req[2] = 1'b0;
    idle(4);
  endtask

  task automatic order_test();
    int         seq [3] = '{3, 1, 2};
    logic [5:0] ed = 6'b011100;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin req[2] = 1'b1; wr[2] = 1'b0; addr[2] = addr_of(seq[i]); end
      else req[2] = 1'b0;
      @(negedge clk);
      chk($sformatf("order_data_ok_%0d", i), 32'(dok[2]), 32'(ed[i]));
      if (i >= 2 && i <= 4)
        chk($sformatf("order_rdata_%0d", i), rd[2], init_val(2, seq[i-2]));
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_test();
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = addr_of(5);
    @(negedge clk); chk("rst_accept0", 32'(aok[1]), 32'h1);
    @(posedge clk); #1; addr[1] = addr_of(6);
    @(negedge clk); chk("rst_accept1", 32'(aok[1]), 32'h1);
    @(posedge clk); #1; req[1] = 1'b0; resetn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("rst_data_ok_%0d", i), 32'(dok[1]), 32'h0);
      if (i < 2)  chk($sformatf("rst_addr_ok_%0d", i), 32'(aok[1]), 32'h0);
      if (i == 2) begin
        chk("rst_release_addr_ok", 32'(aok[1]), 32'h1);
        chk("rst_count", 32'(u1.count_q), 32'h0);
      end
      @(posedge clk); #1;
      if (i == 1) resetn = 1'b1;
    end
    rd_check(1, 5, init_val(1, 5), "rst_mem_retained");
  endtask

  initial begin
    resetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; stall[k] = 1'b0; size[k] = 2'b10;
      wstrb[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_addr_ok", 32'(aok[0]), 32'h0);
    chk("reset_data_ok", 32'(dok[1]), 32'h0);
    chk("reset_rdata", rd[2], 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;

    table_test();

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++)
        put(k, 1'b1, 4'hf, addr_of(i), init_val(k, i));
    idle(6);

    full_test();
    idle(3);
    stall_test();
    order_test();
    idle(3);
    reset_test();
    idle(3);

    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 3; k++) begin
        req[k]   = ($urandom_range(0, 2) != 0);
        wr[k]    = 1'($urandom_range(0, 1));
        stall[k] = ($urandom_range(0, 4) == 0);
        size[k]  = 2'($urandom_range(0, 2));
        wstrb[k] = 4'($urandom);
        wdata[k] = $urandom;
        addr[k]  = {18'($urandom), 8'h00, 4'($urandom), 2'($urandom)};
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin req[k] = 1'b0; stall[k] = 1'b0; end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
